decode_execute_reg: RTL and testbench
=====================================

Name: decode_execute_reg

Overview:
Pipeline register between the decode stage (instruction fields, register data, immediate, and control bits from the control block) and the execute stage. It captures one decoded instruction per cycle under a valid/ready handshake. It detects load-use hazards against the instruction currently held and inserts a one-cycle bubble. It honours a branch/jump flush and keeps saturating bubble and stall performance counters.

Parameters:
DWIDTH, 32, data/instruction width
AWIDTH, 32, PC width
CWIDTH, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
id_valid_i  in  1  decode holds a valid instruction
id_ready_o  out  1  register accepts (or discards) the decode instruction this cycle
id_pc_i  in  AWIDTH  instruction PC
id_insn_i  in  DWIDTH  raw instruction
id_opcode_i  in  7  opcode
id_funct3_i  in  3  funct3
id_rs1_i / id_rs2_i / id_rd_i  in  5 each  register indices
id_rs1_data_i / id_rs2_data_i  in  DWIDTH each  register-file read data
id_imm_i  in  DWIDTH  decoded immediate
id_ctrl_i  in  13  packed {pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren, wbsel[1:0], alusel[3:0]}, MSB first
flush_i  in  1  redirect from execute; kill decode and held instruction
ex_ready_i  in  1  execute accepts the held instruction
ex_valid_o  out  1  held instruction is valid
ex_pc_o, ex_insn_o, ex_funct3_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  widths as inputs  registered payload
ex_ctrl_o  out  13  registered control, gated as below
bubble_cnt_o  out  CWIDTH  load-use bubbles inserted
stall_cnt_o  out  CWIDTH  cycles with ex_valid_o=1 and ex_ready_i=0

Behaviour:
- Reset (async, rst_n=0):
  - ex_valid_o=0; all payload=0 except ex_insn_o=32'h0000_0013 (NOP).
  - ex_ctrl_o=0; both counters=0.
  - Takes effect immediately mid-operation; no partial capture survives.
- advance = !ex_valid_q || ex_ready_i.
- uses_rs1 = opcode in {RTYPE, ITYPE, LOAD, STORE, BRANCH, JALR}. uses_rs2 = opcode in {RTYPE, STORE, BRANCH}.
- load_use = ex_valid_q && ex_memren_q && ex_rd_q!=0 && id_valid_i && ((uses_rs1 && id_rs1_i==ex_rd_q) || (uses_rs2 && id_rs2_i==ex_rd_q)).
- id_ready_o = flush_i || (advance && !load_use). Combinational, no dependency on id_valid_i.
- Next-state priority, highest first:
  1. flush_i: ex_valid_q<=0. Decode instruction is discarded. Payload holds.
  2. !advance: hold everything. Stall counter increments.
  3. load_use: ex_valid_q<=0 (bubble). Decode held (id_ready_o=0). Bubble counter increments.
  4. id_valid_i: capture all payload; ex_valid_q<=1.
  5. Otherwise: ex_valid_q<=0.
- Bubble lasts exactly one cycle: after it, ex_valid_q=0, load_use deasserts, and the dependent instruction is captured next cycle.
- The hazard check ignores ex_rd_q==0. A load that is held (stalled) keeps load_use asserted but is already covered by !advance.
- ex_ctrl_o = ex_valid_q ? ctrl_q : 13'b0. Invalid slots never write regs or memory and never redirect. Other payload outputs are ungated.
- Latency: decode to execute is one cycle. Throughput is one instruction per cycle with no hazard and ex_ready_i=1.
- Counters are CWIDTH-bit, saturate at all-ones with no wrap, and are unaffected by flush_i.
- flush_i together with load_use: flush wins, and the bubble counter does not increment.

Test Plan:
- Streaming: ADDI x1,x0,5 then ADD x2,x1,x1 with ex_ready_i=1 -> captured on consecutive cycles; ex_ctrl_o regwren=1, alusel=ADD; bubble_cnt_o=0.
- Load-use: LW x5,0(x1) captured, then decode ADD x6,x5,x0 -> id_ready_o=0 for 1 cycle; ex_valid_o=0 next cycle; ADD captured the cycle after; bubble_cnt_o=1.
- No false hazard: LW x0,0(x1) followed by ADD x6,x0,x0, and LUI x5 after LW x5 -> no bubble; bubble_cnt_o stays 0.
- Back-pressure: ex_ready_i=0 for 3 cycles with a valid held instruction -> payload stable; id_ready_o=0; stall_cnt_o=3; capture resumes on ex_ready_i=1.
- Flush: flush_i=1 with ex_valid_o=1 and a load-use pending -> next cycle ex_valid_o=0; ex_ctrl_o=0; id_ready_o=1 during flush; bubble_cnt_o unchanged.
- Reset mid-stall: rst_n low while ex_valid_o=1 and ex_ready_i=0 -> ex_valid_o=0 and ex_insn_o=0x00000013 immediately; counters=0.

Source files
------------

// File: rtl/decode_execute_reg.sv
// Decode-to-execute pipeline register.
// Captures one decoded instruction per cycle under a valid/ready handshake,
// inserts a one-cycle bubble on load-use hazards, honours a redirect flush,
// and keeps saturating bubble/stall counters.
module decode_execute_reg #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [AWIDTH-1:0] id_pc_i,
  input  logic [DWIDTH-1:0] id_insn_i,
  input  logic [6:0]        id_opcode_i,
  input  logic [2:0]        id_funct3_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic [DWIDTH-1:0] id_rs1_data_i,
  input  logic [DWIDTH-1:0] id_rs2_data_i,
  input  logic [DWIDTH-1:0] id_imm_i,
  input  logic [12:0]       id_ctrl_i,
  input  logic              flush_i,
  input  logic              ex_ready_i,
  output logic              ex_valid_o,
  output logic [AWIDTH-1:0] ex_pc_o,
  output logic [DWIDTH-1:0] ex_insn_o,
  output logic [2:0]        ex_funct3_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic [DWIDTH-1:0] ex_rs1_data_o,
  output logic [DWIDTH-1:0] ex_rs2_data_o,
  output logic [DWIDTH-1:0] ex_imm_o,
  output logic [12:0]       ex_ctrl_o,
  output logic [CWIDTH-1:0] bubble_cnt_o,
  output logic [CWIDTH-1:0] stall_cnt_o
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Control bit position of memren inside the packed control word
  localparam int CTRL_MEMREN = 7;

  localparam logic [DWIDTH-1:0] NOP_INSN = DWIDTH'(32'h0000_0013);
  localparam logic [CWIDTH-1:0] CNT_ONE  = CWIDTH'(1);

  logic              ex_valid_q;
  logic [AWIDTH-1:0] pc_q;
  logic [DWIDTH-1:0] insn_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  logic [4:0]        rd_q;
  logic [DWIDTH-1:0] rs1_data_q;
  logic [DWIDTH-1:0] rs2_data_q;
  logic [DWIDTH-1:0] imm_q;
  logic [12:0]       ctrl_q;
  logic [CWIDTH-1:0] bubble_q;
  logic [CWIDTH-1:0] stall_q;

  logic advance;
  logic uses_rs1;
  logic uses_rs2;
  logic load_use;

  // Handshake and load-use hazard detection against the held instruction
  always_comb begin
    advance  = !ex_valid_q || ex_ready_i;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode_i)
      OP_RTYPE, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_ITYPE, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
    load_use = ex_valid_q && ctrl_q[CTRL_MEMREN] && (rd_q != 5'd0) && id_valid_i &&
               ((uses_rs1 && (id_rs1_i == rd_q)) || (uses_rs2 && (id_rs2_i == rd_q)));
  end

  assign id_ready_o = flush_i || (advance && !load_use);

  // Valid bit and payload: flush > stall > bubble > capture > drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      pc_q       <= '0;
      insn_q     <= NOP_INSN;
      funct3_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      ctrl_q     <= '0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (!advance) begin
      ex_valid_q <= ex_valid_q;
    end else if (load_use) begin
      ex_valid_q <= 1'b0;
    end else if (id_valid_i) begin
      ex_valid_q <= 1'b1;
      pc_q       <= id_pc_i;
      insn_q     <= id_insn_i;
      funct3_q   <= id_funct3_i;
      rs1_q      <= id_rs1_i;
      rs2_q      <= id_rs2_i;
      rd_q       <= id_rd_i;
      rs1_data_q <= id_rs1_data_i;
      rs2_data_q <= id_rs2_data_i;
      imm_q      <= id_imm_i;
      ctrl_q     <= id_ctrl_i;
    end else begin
      ex_valid_q <= 1'b0;
    end
  end

  // Saturating counters; stall counts every held-valid/not-ready cycle,
  // bubbles count only when the hazard actually wins priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      if (!advance && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (!flush_i && advance && load_use && (bubble_q != '1)) begin
        bubble_q <= bubble_q + CNT_ONE;
      end
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_pc_o       = pc_q;
  assign ex_insn_o     = insn_q;
  assign ex_funct3_o   = funct3_q;
  assign ex_rs1_o      = rs1_q;
  assign ex_rs2_o      = rs2_q;
  assign ex_rd_o       = rd_q;
  assign ex_rs1_data_o = rs1_data_q;
  assign ex_rs2_data_o = rs2_data_q;
  assign ex_imm_o      = imm_q;
  assign ex_ctrl_o     = ex_valid_q ? ctrl_q : 13'b0;
  assign bubble_cnt_o  = bubble_q;
  assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Randomized and directed bench for decode_execute_reg with a
// transaction-level reference model of the pipeline slot.
module tb_decode_execute_reg;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid_i, id_ready_o;
  logic [AW-1:0] id_pc_i;
  logic [DW-1:0] id_insn_i;
  logic [6:0]    id_opcode_i;
  logic [2:0]    id_funct3_i;
  logic [4:0]    id_rs1_i, id_rs2_i, id_rd_i;
  logic [DW-1:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [12:0]   id_ctrl_i;
  logic          flush_i, ex_ready_i, ex_valid_o;
  logic [AW-1:0] ex_pc_o;
  logic [DW-1:0] ex_insn_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [2:0]    ex_funct3_o;
  logic [4:0]    ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [12:0]   ex_ctrl_o;
  logic [CW-1:0] bubble_cnt_o, stall_cnt_o;

  decode_execute_reg #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_pc_i(id_pc_i), .id_insn_i(id_insn_i), .id_opcode_i(id_opcode_i),
    .id_funct3_i(id_funct3_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rd_i(id_rd_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i), .flush_i(flush_i),
    .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_insn_o(ex_insn_o), .ex_funct3_o(ex_funct3_o), .ex_rs1_o(ex_rs1_o),
    .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o), .ex_ctrl_o(ex_ctrl_o),
    .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Opcodes and encoded instructions used by the directed scenarios
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23;
  localparam logic [6:0] OP_BR = 7'h63, OP_JALR = 7'h67, OP_JAL = 7'h6F;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17;
  localparam logic [31:0] ADDI_X1 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] ADD_X2  = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] LW_X5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD_X6  = 32'h0002_8333; // add  x6,x5,x0
  localparam logic [31:0] LW_X0   = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X6Z = 32'h0000_0333; // add  x6,x0,x0
  localparam logic [31:0] LUI_X5  = 32'h0002_82B7; // lui  x5,0x28 (rs1 field = 5)
  // {pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren, wbsel, alusel}
  localparam logic [12:0] C_ADDI = 13'b0_1_1_0_1_0_0_01_0000;
  localparam logic [12:0] C_ADD  = 13'b0_0_1_0_0_0_0_01_0000;
  localparam logic [12:0] C_LW   = 13'b0_1_1_0_1_1_0_00_0000;
  localparam logic [12:0] C_LUI  = 13'b0_1_1_0_1_0_0_01_1010;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        seen_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pipeline slot plus two saturating counters
  logic          m_valid;
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_insn, m_d1, m_d2, m_imm;
  logic [2:0]    m_f3;
  logic [4:0]    m_rs1, m_rs2, m_rd;
  logic [12:0]   m_ctrl;
  int unsigned   m_bub, m_stl;

  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_ST, OP_BR};
  endfunction

  function automatic logic model_hazard();
    // A held load whose destination the incoming instruction reads
    if (!(m_valid && m_ctrl[7] && m_rd != 0 && id_valid_i)) return 1'b0;
    return (reads_rs1(id_opcode_i) && id_rs1_i == m_rd) ||
           (reads_rs2(id_opcode_i) && id_rs2_i == m_rd);
  endfunction

  function automatic logic model_ready();
    return flush_i || ((!m_valid || ex_ready_i) && !model_hazard());
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = '0; m_insn = 32'h13; m_f3 = '0; m_rs1 = '0; m_rs2 = '0;
    m_rd = '0; m_d1 = '0; m_d2 = '0; m_imm = '0; m_ctrl = '0; m_bub = 0; m_stl = 0;
  endtask

  task automatic model_step();
    logic moving, haz;
    moving = !m_valid || ex_ready_i;
    haz    = model_hazard();
    if (!moving && m_stl < CNT_MAX) m_stl++;
    if (flush_i) m_valid = 0;
    else if (!moving) ;
    else if (haz) begin
      m_valid = 0;
      if (m_bub < CNT_MAX) m_bub++;
    end else if (id_valid_i) begin
      m_valid = 1; m_pc = id_pc_i; m_insn = id_insn_i; m_f3 = id_funct3_i;
      m_rs1 = id_rs1_i; m_rs2 = id_rs2_i; m_rd = id_rd_i; m_d1 = id_rs1_data_i;
      m_d2 = id_rs2_data_i; m_imm = id_imm_i; m_ctrl = id_ctrl_i;
    end else m_valid = 0;
  endtask

  task automatic compare_all();
    check_eq("ex_valid", 64'(ex_valid_o), 64'(m_valid));
    check_eq("ex_pc", 64'(ex_pc_o), 64'(m_pc));
    check_eq("ex_insn", 64'(ex_insn_o), 64'(m_insn));
    check_eq("ex_funct3", 64'(ex_funct3_o), 64'(m_f3));
    check_eq("ex_rs1", 64'(ex_rs1_o), 64'(m_rs1));
    check_eq("ex_rs2", 64'(ex_rs2_o), 64'(m_rs2));
    check_eq("ex_rd", 64'(ex_rd_o), 64'(m_rd));
    check_eq("ex_rs1_data", 64'(ex_rs1_data_o), 64'(m_d1));
    check_eq("ex_rs2_data", 64'(ex_rs2_data_o), 64'(m_d2));
    check_eq("ex_imm", 64'(ex_imm_o), 64'(m_imm));
    check_eq("ex_ctrl", 64'(ex_ctrl_o), 64'(m_valid ? m_ctrl : 13'b0));
    check_eq("bubble_cnt", 64'(bubble_cnt_o), 64'(m_bub));
    check_eq("stall_cnt", 64'(stall_cnt_o), 64'(m_stl));
  endtask

  // One clock: check ready mid-cycle, advance model, check outputs after edge
  task automatic cycle();
    @(negedge clk);
    seen_ready = id_ready_o;
    check_eq("id_ready", 64'(id_ready_o), 64'(model_ready()));
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_valid", 64'(ex_valid_o), 64'd0);
    check_eq("rst_insn", 64'(ex_insn_o), 64'h13);
    check_eq("rst_ctrl", 64'(ex_ctrl_o), 64'd0);
    check_eq("rst_bubble", 64'(bubble_cnt_o), 64'd0);
    check_eq("rst_stall", 64'(stall_cnt_o), 64'd0);
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [12:0] ctrl);
    id_valid_i    = v;
    id_insn_i     = insn;
    id_opcode_i   = insn[6:0];
    id_rd_i       = insn[11:7];
    id_funct3_i   = insn[14:12];
    id_rs1_i      = insn[19:15];
    id_rs2_i      = insn[24:20];
    id_ctrl_i     = ctrl;
    id_pc_i       = $urandom;
    id_rs1_data_i = $urandom;
    id_rs2_data_i = $urandom;
    id_imm_i      = $urandom;
  endtask

  task automatic drive_random();
    logic [6:0]  ops [9];
    logic [6:0]  op;
    logic [31:0] insn;
    logic [12:0] ctrl;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC};
    op = ops[$urandom_range(0, 8)];
    insn = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
    ctrl = 13'($urandom);
    ctrl[7] = (op == OP_LD);
    drive($urandom_range(0, 3) != 0, insn, ctrl);
    ex_ready_i = $urandom_range(0, 3) != 0;
    flush_i    = $urandom_range(0, 15) == 0;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;
    drive(1'b0, 32'h13, 13'b0);
    @(posedge clk);
    #1;
    do_reset();

    // Streaming: back-to-back capture, no bubble
    drive(1'b1, ADDI_X1, C_ADDI); cycle();
    check_eq("stream_i0", 64'(ex_insn_o), 64'(ADDI_X1));
    drive(1'b1, ADD_X2, C_ADD); cycle();
    check_eq("stream_i1", 64'(ex_insn_o), 64'(ADD_X2));
    check_eq("stream_regwren", 64'(ex_ctrl_o[10]), 64'd1);
    check_eq("stream_alusel", 64'(ex_ctrl_o[3:0]), 64'd0);
    check_eq("stream_bubble", 64'(bubble_cnt_o), 64'd0);
    drive(1'b0, 32'h13, 13'b0); cycle();

    // Load-use: one bubble, then the dependent instruction lands
    do_reset();
    drive(1'b1, LW_X5, C_LW); cycle();
    drive(1'b1, ADD_X6, C_ADD); cycle();
    check_eq("lu_ready", 64'(seen_ready), 64'd0);
    check_eq("lu_bubble_valid", 64'(ex_valid_o), 64'd0);
    check_eq("lu_bubble_cnt", 64'(bubble_cnt_o), 64'd1);
    cycle();
    check_eq("lu_capture", 64'(ex_insn_o), 64'(ADD_X6));
    check_eq("lu_capture_valid", 64'(ex_valid_o), 64'd1);
    drive(1'b0, 32'h13, 13'b0); cycle();

    // No false hazard: x0 destination, and LUI not reading rs1
    do_reset();
    drive(1'b1, LW_X0, C_LW); cycle();
    drive(1'b1, ADD_X6Z, C_ADD); cycle();
    check_eq("nofh_x0", 64'(ex_insn_o), 64'(ADD_X6Z));
    drive(1'b1, LW_X5, C_LW); cycle();
    drive(1'b1, LUI_X5, C_LUI); cycle();
    check_eq("nofh_lui", 64'(ex_insn_o), 64'(LUI_X5));
    check_eq("nofh_bubble", 64'(bubble_cnt_o), 64'd0);
    drive(1'b0, 32'h13, 13'b0); cycle();

    // Back-pressure: payload holds for three cycles, then resumes
    do_reset();
    drive(1'b1, ADDI_X1, C_ADDI); cycle();
    ex_ready_i = 1'b0;
    drive(1'b1, ADD_X2, C_ADD);
    for (int unsigned i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_ready", 64'(seen_ready), 64'd0);
      check_eq("bp_hold", 64'(ex_insn_o), 64'(ADDI_X1));
    end
    check_eq("bp_stall_cnt", 64'(stall_cnt_o), 64'd3);
    ex_ready_i = 1'b1; cycle();
    check_eq("bp_resume", 64'(ex_insn_o), 64'(ADD_X2));

    // Flush beats a pending load-use
    do_reset();
    drive(1'b1, LW_X5, C_LW); cycle();
    drive(1'b1, ADD_X6, C_ADD); flush_i = 1'b1; cycle();
    check_eq("fl_ready", 64'(seen_ready), 64'd1);
    check_eq("fl_valid", 64'(ex_valid_o), 64'd0);
    check_eq("fl_ctrl", 64'(ex_ctrl_o), 64'd0);
    check_eq("fl_bubble", 64'(bubble_cnt_o), 64'd0);
    flush_i = 1'b0;

    // Stall counter saturation, then reset in the middle of the stall
    do_reset();
    drive(1'b1, ADDI_X1, C_ADDI); cycle();
    ex_ready_i = 1'b0;
    for (int unsigned i = 0; i < 18; i++) cycle();
    check_eq("stall_sat", 64'(stall_cnt_o), 64'(CNT_MAX));
    do_reset();
    ex_ready_i = 1'b1;

    // Randomized traffic against the model
    for (int unsigned i = 0; i < 600; i++) begin
      drive_random();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
